serial_rx_reg_16bits: RTL and testbench

//  Serial-to-parallel receiver; the receive end of the 16-bit MSB-first circular-shift serial link.

---
 rtl/serial_rx_reg_16bits_pkg.sv | 13 +
 rtl/serial_rx_reg_16bits.sv | 96 +++++++++
 tb/tb_serial_rx_reg_16bits.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_reg_16bits_pkg.sv
// Shared constants for the serial receiver: default word width and FSM state encoding.
package serial_rx_reg_16bits_pkg;

  localparam int   WIDTH_DEF = 16;
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_RECV   = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    RECV = ST_RECV
  } state_t;

endpackage

// File: rtl/serial_rx_reg_16bits.sv
// Serial-to-parallel receiver: collects WIDTH bits MSB first into a single-entry valid/ready slot.
// Word is visible the cycle after its last bit; a word completing into a busy slot is dropped and flags overrun.
import serial_rx_reg_16bits_pkg::*;

module serial_rx_reg_16bits #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             shift_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clear_overrun
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] word;
  logic             start;
  logic             advance;
  logic             complete;
  logic             slot_free;

  always_comb begin
    state_nxt = state;
    word      = {shreg[WIDTH-2:0], shift_in};
    // A frame_start restarts from any state and outranks completion.
    start     = bit_valid && frame_start;
    advance   = (state == RECV) && bit_valid && !frame_start;
    complete  = advance && (count == LAST);
    slot_free = !out_valid || out_ready;
    if (start)
      state_nxt = RECV;
    else if (complete)
      state_nxt = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      shreg <= '0;
    else if (start)
      shreg <= {{(WIDTH-1){1'b0}}, shift_in};
    else if (advance)
      shreg <= word;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      count <= '0;
    else if (start)
      count <= CW'(1);
    else if (complete)
      count <= '0;
    else if (advance)
      count <= count + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else if (complete && slot_free) begin
      data_out  <= word;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A drop in the same cycle as clear_overrun leaves the flag set.
  always_ff @(posedge clock) begin
    if (!reset_n)
      overrun <= 1'b0;
    else if (complete && !slot_free)
      overrun <= 1'b1;
    else if (clear_overrun)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_serial_rx_reg_16bits.sv
// Directed bench for serial_rx_reg_16bits; accepted words are checked by a queue-based scoreboard.
module tb_serial_rx_reg_16bits;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        shift_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] data_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overrun;
  logic        clear_overrun = 1'b0;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];

  serial_rx_reg_16bits #(.WIDTH(16)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .shift_in      (shift_in),
    .bit_valid     (bit_valid),
    .frame_start   (frame_start),
    .data_out      (data_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_word: got %h, expected none", data_out);
      end else begin
        check("word", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_word(input logic [15:0] w, input int gapmax, input int nbits,
                           input bit rdy_last, input bit clr_last);
    for (int i = 15; i > 15 - nbits; i--) begin
      if (gapmax > 0) repeat ($urandom_range(gapmax, 0)) tick();
      shift_in    = w[i];
      bit_valid   = 1'b1;
      frame_start = (i == 15);
      if (i == 0 && rdy_last) out_ready = 1'b1;
      if (i == 0 && clr_last) clear_overrun = 1'b1;
      tick();
      bit_valid   = 1'b0;
      frame_start = 1'b0;
      if (i == 0 && rdy_last) out_ready = 1'b0;
      if (i == 0 && clr_last) clear_overrun = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] tx;

    // 1. reset with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      shift_in      = 1'($urandom_range(1, 0));
      bit_valid     = 1'($urandom_range(1, 0));
      frame_start   = 1'($urandom_range(1, 0));
      out_ready     = 1'($urandom_range(1, 0));
      clear_overrun = 1'($urandom_range(1, 0));
      tick();
    end
    check("rst_data", {16'h0, data_out}, 32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    shift_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; clear_overrun = 1'b0;
    reset_n = 1'b1;
    tick();

    // 2. basic frame, then a single-cycle ready pulse
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 0, 16, 1'b0, 1'b0);
    check("basic_valid", {31'h0, out_valid}, 32'h1);
    check("basic_data", {16'h0, data_out}, 32'h0000A5C3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("basic_consumed", {31'h0, out_valid}, 32'h0);
    check("basic_hold", {16'h0, data_out}, 32'h0000A5C3);

    // 3. gapped frame
    out_ready = 1'b1;
    exp_q.push_back(16'h1234);
    send_word(16'h1234, 3, 16, 1'b0, 1'b0);
    check("gap_data", {16'h0, data_out}, 32'h00001234);
    tick();
    tick();

    // 4. restart mid-frame
    send_word(16'hFFFF, 0, 5, 1'b0, 1'b0);
    check("restart_no_word", {31'h0, out_valid}, 32'h0);
    exp_q.push_back(16'h0F0F);
    send_word(16'h0F0F, 0, 16, 1'b0, 1'b0);
    tick();
    tick();
    check("restart_single", exp_q.size(), 0);
    check("restart_data", {16'h0, data_out}, 32'h00000F0F);
    out_ready = 1'b0;

    // 5. overrun
    exp_q.push_back(16'hBEEF);
    send_word(16'hBEEF, 0, 16, 1'b0, 1'b0);
    send_word(16'hCAFE, 0, 16, 1'b0, 1'b0);
    check("ovr_data", {16'h0, data_out}, 32'h0000BEEF);
    check("ovr_valid", {31'h0, out_valid}, 32'h1);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("ovr_cleared", {31'h0, overrun}, 32'h0);
    send_word(16'h5555, 0, 16, 1'b0, 1'b1);
    check("ovr_set_wins", {31'h0, overrun}, 32'h1);
    check("ovr_data2", {16'h0, data_out}, 32'h0000BEEF);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_q.push_back(16'hBEEF);
    send_word(16'hBEEF, 0, 16, 1'b0, 1'b0);
    exp_q.push_back(16'hCAFE);
    send_word(16'hCAFE, 0, 16, 1'b1, 1'b0);
    check("ready_data", {16'h0, data_out}, 32'h0000CAFE);
    check("ready_valid", {31'h0, out_valid}, 32'h1);
    check("ready_no_ovr", {31'h0, overrun}, 32'h0);
    out_ready = 1'b1;
    tick();

    // 6. reset mid-frame, then loopback from a circular-shift transmitter
    send_word(16'hFFFF, 0, 8, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_data", {16'h0, data_out}, 32'h0);
    tx = 16'h8001;
    exp_q.push_back(16'h8001);
    for (int i = 0; i < 16; i++) begin
      shift_in    = tx[15];
      bit_valid   = 1'b1;
      frame_start = (i == 0);
      tick();
      tx = {tx[14:0], tx[15]};
    end
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    check("loop_data", {16'h0, data_out}, 32'h00008001);
    tick();
    tick();
    check("queue_drained", exp_q.size(), 0);
    check("final_valid", {31'h0, out_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
